// File: rtl/dnn_mac_lane_array.sv
// Multi-lane signed MAC engine: NUM_CH activations times one broadcast weight,
// accumulated over cfg_k+1 beats, then shifted, optionally ReLU'd and saturated.
//   state | meaning
//   IDLE  | waiting for start, outputs quiet
//   ACCUM | accepting beats until the cfg_k-th one
//   POST  | requantise accumulators into of_out
//   DRAIN | result presented until out_ready
module dnn_mac_lane_array #(
  parameter int NUM_CH     = 15,
  parameter int DATA_WIDTH = 8,
  parameter int ACC_WIDTH  = 24,
  parameter int K_WIDTH    = 8,
  parameter int OUT_WIDTH  = 16
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic                                 start,
  input  logic [K_WIDTH-1:0]                   cfg_k,
  input  logic [4:0]                           cfg_shift,
  input  logic                                 cfg_relu,
  input  logic                                 in_valid,
  output logic                                 in_ready,
  input  logic [NUM_CH-1:0][DATA_WIDTH-1:0]    if_in,
  input  logic [DATA_WIDTH-1:0]                wt_in,
  output logic                                 out_valid,
  input  logic                                 out_ready,
  output logic [NUM_CH-1:0][OUT_WIDTH-1:0]     of_out,
  output logic                                 busy,
  output logic                                 done
);

  localparam int PROD_W = 2 * DATA_WIDTH;

  // Saturation bounds expressed at accumulator width so comparisons stay signed.
  localparam logic signed [ACC_WIDTH-1:0] SAT_MAX =
    {{(ACC_WIDTH-OUT_WIDTH+1){1'b0}}, {(OUT_WIDTH-1){1'b1}}};
  localparam logic signed [ACC_WIDTH-1:0] SAT_MIN =
    {{(ACC_WIDTH-OUT_WIDTH+1){1'b1}}, {(OUT_WIDTH-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, ACCUM, POST, DRAIN} state_t;

  state_t                               state_q, state_d;
  logic [K_WIDTH-1:0]                   k_q, k_d;
  logic [K_WIDTH-1:0]                   cnt_q, cnt_d;
  logic [4:0]                           shift_q, shift_d;
  logic                                 relu_q, relu_d;
  logic signed [ACC_WIDTH-1:0]          acc_q [NUM_CH];
  logic signed [ACC_WIDTH-1:0]          acc_d [NUM_CH];
  logic signed [PROD_W-1:0]             prod  [NUM_CH];
  logic [NUM_CH-1:0][OUT_WIDTH-1:0]     of_out_q, of_out_d;
  logic                                 in_ready_q, in_ready_d;
  logic                                 out_valid_q, out_valid_d;
  logic                                 busy_q, busy_d;
  logic                                 done_q, done_d;

  function automatic logic [OUT_WIDTH-1:0] requant(
    input logic signed [ACC_WIDTH-1:0] acc,
    input logic [4:0]                  shift,
    input logic                        relu
  );
    logic signed [ACC_WIDTH-1:0] r;
    // Shifts past the accumulator width collapse to the sign fill.
    if (int'(shift) >= ACC_WIDTH) begin
      r = acc[ACC_WIDTH-1] ? '1 : '0;
    end else begin
      r = acc >>> shift;
    end
    if (relu && r[ACC_WIDTH-1]) begin
      r = '0;
    end
    if (r > SAT_MAX) begin
      requant = SAT_MAX[OUT_WIDTH-1:0];
    end else if (r < SAT_MIN) begin
      requant = SAT_MIN[OUT_WIDTH-1:0];
    end else begin
      requant = r[OUT_WIDTH-1:0];
    end
  endfunction

  always_comb begin
    for (int i = 0; i < NUM_CH; i++) begin
      prod[i] = $signed(if_in[i]) * $signed(wt_in);
    end
  end

  always_comb begin
    state_d  = state_q;
    k_d      = k_q;
    cnt_d    = cnt_q;
    shift_d  = shift_q;
    relu_d   = relu_q;
    of_out_d = of_out_q;
    done_d   = 1'b0;
    for (int i = 0; i < NUM_CH; i++) begin
      acc_d[i] = acc_q[i];
    end

    case (state_q)
      IDLE: begin
        if (start) begin
          k_d     = cfg_k;
          shift_d = cfg_shift;
          relu_d  = cfg_relu;
          cnt_d   = '0;
          for (int i = 0; i < NUM_CH; i++) begin
            acc_d[i] = '0;
          end
          state_d = ACCUM;
        end
      end
      ACCUM: begin
        if (in_valid) begin
          for (int i = 0; i < NUM_CH; i++) begin
            acc_d[i] = acc_q[i] +
                       $signed({{(ACC_WIDTH-PROD_W){prod[i][PROD_W-1]}}, prod[i]});
          end
          cnt_d = cnt_q + K_WIDTH'(1);
          if (cnt_q == k_q) begin
            state_d = POST;
          end
        end
      end
      POST: begin
        for (int i = 0; i < NUM_CH; i++) begin
          of_out_d[i] = requant(acc_q[i], shift_q, relu_q);
        end
        state_d = DRAIN;
      end
      DRAIN: begin
        if (out_ready) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase

    // Handshake outputs are decodes of the next state, so they come straight from flops.
    in_ready_d  = (state_d == ACCUM);
    out_valid_d = (state_d == DRAIN);
    busy_d      = (state_d != IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      k_q         <= '0;
      cnt_q       <= '0;
      shift_q     <= '0;
      relu_q      <= 1'b0;
      of_out_q    <= '0;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      for (int i = 0; i < NUM_CH; i++) begin
        acc_q[i] <= '0;
      end
    end else begin
      state_q     <= state_d;
      k_q         <= k_d;
      cnt_q       <= cnt_d;
      shift_q     <= shift_d;
      relu_q      <= relu_d;
      of_out_q    <= of_out_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      for (int i = 0; i < NUM_CH; i++) begin
        acc_q[i] <= acc_d[i];
      end
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign of_out    = of_out_q;

endmodule

// File: doc/dnn_mac_lane_array.md
# dnn_mac_lane_array

Parametrised multi-channel MAC engine with runtime-configurable reduction length, requantisation and valid/ready handshakes on both streams. NUM_CH signed activations per beat are multiplied by one broadcast signed weight and accumulated over cfg_k+1 beats. Results are shifted, optionally ReLU'd, saturated and presented as one output vector. It sits between the activation FIFO bank / weight SRAM read path and the output FIFO bank, and replaces the fixed-function PE array + control FSM pairing in the next accelerator generation.

## Interface
- NUM_CH, 15: number of parallel MAC lanes (activation/output channels)
- DATA_WIDTH, 8: signed activation and weight width
- ACC_WIDTH, 24: signed accumulator width
- K_WIDTH, 8: width of cfg_k; reduction length is 1 to 2^K_WIDTH beats
- OUT_WIDTH, 16: signed output width after requantisation
- clk  in  1  clock
- rst  in  1  reset; synchronous to clk, active-high
- start  in  1  begin a job; sampled only in IDLE
- cfg_k  in  K_WIDTH  reduction length minus one; latched on accepted start
- cfg_shift  in  5  arithmetic right shift applied to accumulator; latched on start
- cfg_relu  in  1  1 = clamp negatives to 0; latched on start
- in_valid  in  1  activation/weight beat valid
- in_ready  out  1  beat accepted when in_valid & in_ready
- if_in  in  NUM_CH x DATA_WIDTH  signed activations, one per lane
- wt_in  in  DATA_WIDTH  signed weight, broadcast to all lanes
- out_valid  out  1  of_out holds a result
- out_ready  in  1  downstream accepts when out_valid & out_ready
- of_out  out  NUM_CH x OUT_WIDTH  signed requantised results
- busy  out  1  high in any state other than IDLE
- done  out  1  one-cycle pulse after result handshake

## Operation
- States: IDLE, ACCUM, POST, DRAIN.
- IDLE: in_ready=0, out_valid=0, busy=0. start=1 latches cfg_k/cfg_shift/cfg_relu, clears all accumulators and beat counter, and moves to ACCUM.
- ACCUM: in_ready=1. Each accepted beat sets acc[i] += sext(if_in[i]*wt_in) for every lane and increments the beat counter. The beat with counter==cfg_k is accepted, then the block moves to POST. in_valid=0 stalls without state change.
- POST (1 cycle): in_ready=0. For each lane, r = acc[i] >>> cfg_shift (arithmetic); if cfg_relu and r<0 then r=0; saturate r to [-2^(OUT_WIDTH-1), 2^(OUT_WIDTH-1)-1]; register into of_out. Then move to DRAIN.
- DRAIN: out_valid=1, of_out stable until handshake. On out_valid & out_ready, move to IDLE and assert done on the following cycle, which is the first IDLE cycle.
- start outside IDLE is ignored; config inputs outside the start cycle are ignored.
- Arithmetic: the product is the full 2*DATA_WIDTH signed value, sign-extended to ACC_WIDTH. The accumulator wraps modulo 2^ACC_WIDTH. No overflow is possible when ACC_WIDTH >= 2*DATA_WIDTH+K_WIDTH.
- cfg_shift >= ACC_WIDTH yields 0 for non-negative and -1 for negative accumulators before ReLU/saturation.
- rst in any state, including mid-ACCUM or DRAIN with a pending result, behaves as follows: next cycle is IDLE, accumulators and counter are 0, the pending result is discarded, and no done pulse is issued.

## Timing
- Reset values: in_ready=0, out_valid=0, busy=0, done=0, of_out=all zeros.
- start in cycle t puts the block in ACCUM at t+1, with in_ready high from t+1.
- With no stalls, beats are accepted at t+1..t+K (K=cfg_k+1), POST is at t+K+1, and out_valid rises at t+K+2.
- Minimum start-to-out_valid latency is K+2 cycles. Each in_valid gap adds one cycle.
- With out_ready held high, the handshake occurs in the first DRAIN cycle. done pulses the next cycle, and a new start is accepted in that same cycle.
- of_out is registered, and it keeps its last value after DRAIN until the next POST or rst.
- in_ready is a registered state decode, with no combinational path from in_valid or out_ready.

## Test plan
- Basic dot product: cfg_k=2, shift=0, relu=0. Three beats with if_in[all]=3 and wt_in=4, -2, 5. Required: of_out[all]=21, out_valid at start+5, done one cycle after handshake.
- Signed/ReLU: cfg_k=0, lane0 if=-7, lane1 if=7, wt=9, relu=1. Required: of_out[0]=0 and of_out[1]=63. The same stimulus with relu=0 gives of_out[0]=-63.
- Saturation/shift: cfg_k=255, every lane if=-128, wt=-128 gives acc=4194304. With shift=0, of_out=32767. With shift=8, of_out=16384. With shift=31, of_out=0.
- Backpressure: hold in_valid low on alternate cycles and hold out_ready low for 5 DRAIN cycles. Required: correct sum, of_out stable while stalled, busy high throughout, exactly one done pulse.
- Reset mid-operation: assert rst after 2 of 4 beats. Required: IDLE next cycle, all outputs 0, no done. A fresh job afterwards gives a result unaffected by the aborted partial sum.
- Ignored start: pulse start during ACCUM and during DRAIN with different cfg_k. Required: no restart, original config used, result unchanged.
